// File: rtl/systolic_deskew.sv
// Re-aligns the skewed diagonal output of a systolic array into whole rows, tags batch position and buffers rows in a small FIFO.
// Optional macro SYSTOLIC_DESKEW_ROWIDX_EN adds out_row_idx, the row index carried alongside each buffered row.
module systolic_deskew #(
    parameter int BitSize     = 8,
    parameter int NumOfNerves = 2,
    parameter int NumOfRows   = 4,
    parameter int FifoDepth   = 4
) (
    input  logic                             clk,
    input  logic                             res_n,
    input  logic                             in_valid,
    input  logic                             in_start,
    input  logic [NumOfNerves*BitSize-1:0]   in_data,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [NumOfNerves*BitSize-1:0]   out_data,
    output logic                             out_done,
    output logic                             out_stall,
    output logic                             out_overflow
`ifdef SYSTOLIC_DESKEW_ROWIDX_EN
    ,
    output logic [((NumOfRows > 1) ? $clog2(NumOfRows) : 1)-1:0] out_row_idx
`endif
);

    localparam int DW = NumOfNerves * BitSize;
    localparam int RW = (NumOfRows > 1) ? $clog2(NumOfRows) : 1;
    localparam int TD = NumOfNerves - 1;
    localparam int PW = $clog2(FifoDepth);
    localparam int CW = $clog2(FifoDepth + 1);

    typedef struct packed {
        logic          vld;
        logic          last;
`ifdef SYSTOLIC_DESKEW_ROWIDX_EN
        logic [RW-1:0] idx;
`endif
    } tag_t;

    typedef struct packed {
        logic          last;
`ifdef SYSTOLIC_DESKEW_ROWIDX_EN
        logic [RW-1:0] idx;
`endif
        logic [DW-1:0] dat;
    } entry_t;

    // ---------------- row counter / tag generation ----------------
    logic [RW-1:0] r_row_cnt;
    logic          r_active;
    logic [RW-1:0] w_tag_idx;
    logic          w_tag_last;
    tag_t          w_tag_in;
    tag_t          w_tag_out;

    assign w_tag_idx  = in_start ? '0 : r_row_cnt;
    assign w_tag_last = (w_tag_idx == RW'(NumOfRows - 1));

    always_comb begin
        w_tag_in      = '0;
        w_tag_in.vld  = in_valid && (in_start || r_active);
        w_tag_in.last = w_tag_last;
`ifdef SYSTOLIC_DESKEW_ROWIDX_EN
        w_tag_in.idx  = w_tag_idx;
`endif
    end

    // A restart mid-batch simply resets the count; tags already in flight are untouched.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_row_cnt <= '0;
            r_active  <= 1'b0;
        end else if (in_valid) begin
            if (in_start) begin
                r_row_cnt <= RW'(1);
                r_active  <= (NumOfRows > 1);
            end else if (r_active) begin
                if (w_tag_last) begin
                    r_row_cnt <= '0;
                    r_active  <= 1'b0;
                end else begin
                    r_row_cnt <= r_row_cnt + RW'(1);
                end
            end
        end
    end

    // ---------------- tag pipeline, matched to the deepest lane ----------------
    generate
        if (TD == 0) begin : g_tag_bypass
            assign w_tag_out = w_tag_in;
        end else begin : g_tag_pipe
            tag_t r_tag [TD];
            always_ff @(posedge clk) begin
                if (!res_n) begin
                    for (int i = 0; i < TD; i++) r_tag[i] <= '0;
                end else if (in_valid) begin
                    r_tag[0] <= w_tag_in;
                    for (int i = 1; i < TD; i++) r_tag[i] <= r_tag[i-1];
                end
            end
            assign w_tag_out = r_tag[TD-1];
        end
    endgenerate

    // ---------------- per-lane deskew delay lines ----------------
    logic [DW-1:0] w_row_dat;

    generate
        for (genvar k = 0; k < NumOfNerves; k++) begin : g_lane
            localparam int D  = NumOfNerves - 1 - k;
            localparam int SL = (NumOfNerves - 1 - k) * BitSize;
            logic [BitSize-1:0] w_lane_in;
            assign w_lane_in = in_data[SL +: BitSize];
            if (D == 0) begin : g_thru
                assign w_row_dat[SL +: BitSize] = w_lane_in;
            end else begin : g_dly
                logic [BitSize-1:0] r_sr [D];
                always_ff @(posedge clk) begin
                    if (!res_n) begin
                        for (int i = 0; i < D; i++) r_sr[i] <= '0;
                    end else if (in_valid) begin
                        r_sr[0] <= w_lane_in;
                        for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
                    end
                end
                assign w_row_dat[SL +: BitSize] = r_sr[D-1];
            end
        end
    endgenerate

    // ---------------- output row FIFO ----------------
    entry_t        r_mem [FifoDepth];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    entry_t        w_wr_ent;
    entry_t        w_head;
    logic          w_wr;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FifoDepth - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        w_wr_ent      = '0;
        w_wr_ent.last = w_tag_out.last;
`ifdef SYSTOLIC_DESKEW_ROWIDX_EN
        w_wr_ent.idx  = w_tag_out.idx;
`endif
        w_wr_ent.dat  = w_row_dat;
    end

    assign w_wr   = in_valid && w_tag_out.vld;
    assign w_full = (r_count == CW'(FifoDepth));
    assign w_pop  = out_valid && out_ready;
    // A pop frees the slot being written even when full, so both succeed.
    assign w_push = w_wr && (!w_full || w_pop);
    assign w_drop = w_wr && w_full && !w_pop;
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_ent;
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign out_valid    = (r_count != '0);
    assign out_data     = w_head.dat;
    assign out_done     = w_pop && w_head.last;
    assign out_stall    = (r_count >= CW'(FifoDepth - 1));
    assign out_overflow = r_overflow;
`ifdef SYSTOLIC_DESKEW_ROWIDX_EN
    assign out_row_idx  = out_valid ? w_head.idx : '0;
`endif

endmodule

// File: doc/systolic_deskew.md
SYSTOLIC_DESKEW -- requirements
Module: systolic_deskew

Interface
REQ-001 Parameter BitSize, default 8, width of one result element.
REQ-002 Parameter NumOfNerves, default 2, columns (lanes) per row, >=1.
REQ-003 Parameter NumOfRows, default 4, rows per batch, >=1.
REQ-004 Parameter FifoDepth, default 4, output row FIFO depth, >=2.
REQ-005 Clocking is one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 res_n  in  1  synchronous active-low reset.
REQ-008 in_valid  in  1  advance strobe from the array; lanes shift only when 1.
REQ-009 in_start  in  1  marks column 0 of row 0 of a batch; qualified by in_valid.
REQ-010 in_data  in  NumOfNerves*BitSize  skewed diagonal; column k in slice NumOfNerves-1-k.
REQ-011 out_ready  in  1  downstream accepts a row.
REQ-012 out_valid  out  1  row available on out_data.
REQ-013 out_data  out  NumOfNerves*BitSize  row-aligned; same lane ordering as in_data.
REQ-014 out_done  out  1  one-cycle pulse when the batch's last row is accepted.
REQ-015 out_stall  out  1  request for upstream to drop in_valid.
REQ-016 out_overflow  out  1  sticky error, row dropped.

Function
REQ-017 An advance cycle is any cycle with in_valid=1; all lane delays, tag pipelines and row counter SHALL hold state otherwise.
REQ-018 Lane k SHALL be delayed NumOfNerves-1-k advance cycles (lane NumOfNerves-1 passes through undelayed).
REQ-019 Column 0 of row r SHALL enter on the r-th advance cycle after the in_start advance cycle (r=0..NumOfRows-1); a row-tag plus last-tag (r=NumOfRows-1) SHALL enter a NumOfNerves-1-deep tag pipeline.
REQ-020 On an advance cycle where the tag emerges, the aligned row SHALL be written into the FIFO with its last flag.
REQ-021 Latency: with FIFO empty, out_valid SHALL rise exactly NumOfNerves advance cycles after the in_start advance cycle (registered FIFO output).
REQ-022 in_start during an active batch SHALL restart the row count at 0; rows already tagged complete normally.
REQ-023 Rows SHALL be popped on out_valid && out_ready, FIFO order, no data modification.
REQ-024 out_done SHALL pulse in the cycle a row flagged last is popped.
REQ-025 out_stall SHALL be combinational: FIFO count >= FifoDepth-1.
REQ-026 Write and pop in the same cycle SHALL both succeed, including when full.
REQ-027 Write when full without pop SHALL drop the incoming row, keep contents, set out_overflow until reset.
REQ-028 Untagged in_data SHALL be ignored.

Reset
REQ-029 With res_n=0 at a rising edge: out_valid=0, out_done=0, out_stall=0, out_overflow=0, FIFO empty, tags and row counter cleared.
REQ-030 Reset mid-batch SHALL discard all in-flight and buffered rows; no out_done for the aborted batch.

Configuration
REQ-031 Macro SYSTOLIC_DESKEW_ROWIDX_EN defined: output port out_row_idx, width max(1,$clog2(NumOfRows)), SHALL carry the row index r stored alongside each FIFO entry, 0 at reset.
REQ-032 Macro undefined: port out_row_idx and its storage SHALL be absent; all other behaviour identical.

Verification (NumOfNerves=2, BitSize=8, NumOfRows=2, FifoDepth=4)
REQ-033 res_n=0 for 2 cycles with in_valid=1, in_start=1 -> out_valid=0, out_done=0, out_stall=0, out_overflow=0.
REQ-034 c0: in_start=1, col0=0x11; c1: col0=0x21, col1=0x12; c2: col1=0x22; out_ready=1 -> c2 row {0x11,0x12}, c3 row {0x21,0x22}, out_done=1 in c3.
REQ-035 Same stimulus with in_valid=0 inserted at c1 (data held) -> identical rows, each one cycle later.
REQ-036 out_ready=0, two batches back-to-back -> out_stall=1 at count 3; ignore stall, fifth row -> out_overflow=1, first four rows intact on drain.
REQ-037 FIFO full, row written with out_ready=1 -> count stays 4, no overflow, order preserved.
REQ-038 SYSTOLIC_DESKEW_ROWIDX_EN defined, REQ-034 stimulus -> out_row_idx 0 then 1.
